// File: rtl/seg7_pkg.sv
// Shared constants, digit type and BCD helper for the 7-segment scan blocks.
package seg7_pkg;

    localparam int BCD_MAX          = 9;
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_REFRESH_DIV  = 50000;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic bcd_valid(bcd_digit_t d);
        return (d <= bcd_digit_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Slot-rate prescaler: counts 0..REFRESH_DIV-1, flags the terminal count (tick)
// and the first cycle of each slot (guard).
module seg7_prescaler #(
    parameter int REFRESH_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic guard
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] r_pcnt;
    logic          w_last;

    assign w_last = (r_pcnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_last) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign tick  = w_last;
    assign guard = (r_pcnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered BCD value.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    err,
    output logic [3:0]              bcd_out,
    output logic                    err_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                               w_tick;
    logic                               w_guard;
    logic                               w_commit;
    logic                               w_idx_last;

    logic [IDX_W-1:0]                   r_idx;
    bcd_digit_t [NUM_DIGITS-1:0]        r_pend;
    bcd_digit_t [NUM_DIGITS-1:0]        r_disp;
    logic [NUM_DIGITS-1:0]              r_pend_bad;
    logic [NUM_DIGITS-1:0]              r_disp_bad;
    logic                               r_pending;

    logic [NUM_DIGITS-1:0]              w_in_bad;
    bcd_digit_t [NUM_DIGITS-1:0]        w_disp_next;
    logic [NUM_DIGITS-1:0]              w_disp_bad_next;
    bcd_digit_t                         w_cur_bcd;
    logic                               w_cur_bad;
    logic                               w_blank;
    logic [NUM_DIGITS-1:0]              w_en_n;

    logic [3:0]                         r_bcd_out;
    logic                               r_err_out;
    logic [NUM_DIGITS-1:0]              r_digit_en_n;
    logic                               r_frame_start;

    seg7_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick  (w_tick),
        .guard (w_guard)
    );

    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    // First cycle of slot 0: the frame boundary where the pending buffer commits
    assign w_commit   = w_guard && (r_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_in_check
            assign w_in_bad[gi] = !bcd_valid(value_in[4*gi +: 4]);
        end
    endgenerate

    // A load coinciding with the commit stays pending for the following frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_bad <= '0;
            r_disp     <= '0;
            r_disp_bad <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_disp     <= w_disp_next;
            r_disp_bad <= w_disp_bad_next;
            if (load) begin
                r_pend     <= value_in;
                r_pend_bad <= w_in_bad;
                r_pending  <= 1'b1;
            end else if (w_commit) begin
                r_pending  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_disp_next     = r_disp;
        w_disp_bad_next = r_disp_bad;
        if (w_commit && r_pending) begin
            w_disp_next     = r_pend;
            w_disp_bad_next = r_pend_bad;
        end
    end

    assign w_cur_bcd = w_disp_next[r_idx];
    assign w_cur_bad = w_disp_bad_next[r_idx];

`ifdef SEG7_SCAN_LZB_EN
    // w_lz[k]: digit k and every higher digit are clean zeros
    logic [NUM_DIGITS-1:0] w_lz;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_lz[gi] = (r_disp[gi] == '0) && !r_disp_bad[gi];
            end else begin : g_rest
                assign w_lz[gi] = (r_disp[gi] == '0) && !r_disp_bad[gi] && w_lz[gi+1];
            end
        end
    endgenerate

    assign w_blank = w_lz[r_idx] && (r_idx != '0) && !err;
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_en_n = '1;
        if (!w_guard && !w_blank) begin
            w_en_n[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd_out     <= '0;
            r_err_out     <= 1'b0;
            r_digit_en_n  <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_bcd_out     <= w_cur_bcd;
            r_err_out     <= w_cur_bad | err;
            r_digit_en_n  <= w_en_n;
            r_frame_start <= w_commit;
        end
    end

    assign bcd_out     = r_bcd_out;
    assign err_out     = r_err_out;
    assign digit_en_n  = r_digit_en_n;
    assign pending     = r_pending;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic        err;
    logic [3:0]  bcd_out;
    logic        err_out;
    logic [3:0]  digit_en_n;
    logic        pending;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .err         (err),
        .bcd_out     (bcd_out),
        .err_out     (err_out),
        .digit_en_n  (digit_en_n),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Per-digit anode patterns packed {d3,d2,d1,d0}
    localparam logic [15:0] EN_ALL = 16'h7BDE;
`ifdef SEG7_SCAN_LZB_EN
    localparam logic [15:0] EN_0040 = 16'hFFDE;
    localparam logic [15:0] EN_0000 = 16'hFFFE;
`else
    localparam logic [15:0] EN_0040 = EN_ALL;
    localparam logic [15:0] EN_0000 = EN_ALL;
`endif

    typedef struct {
        logic [15:0] value;
        logic        err;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
        logic [15:0] exp_en;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(input string name);
        for (int i = 0; i < 40 && frame_start !== 1'b1; i++) @(negedge clk);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL %s frame_start timeout got=%b exp=1", name, frame_start);
        end
    endtask

    // Called at the negedge where frame_start is high; returns 16 cycles later
    task automatic check_frame(input logic [15:0] eb, input logic [3:0] ee, input logic [15:0] en);
        int s;
        int c;
        for (int k = 0; k < 16; k++) begin
            s = k / 4;
            c = k % 4;
            chk($sformatf("frame_start k=%0d", k), 16'(frame_start), 16'(k == 0));
            chk($sformatf("bcd_out k=%0d", k), 16'(bcd_out), 16'(eb[s*4 +: 4]));
            chk($sformatf("err_out k=%0d", k), 16'(err_out), 16'(ee[s]));
            chk($sformatf("digit_en_n k=%0d", k), 16'(digit_en_n),
                (c == 0) ? 16'h000F : 16'(en[s*4 +: 4]));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] old;

        vec[0] = '{value: 16'h1234, err: 1'b0, exp_bcd: 16'h1234, exp_err: 4'b0000, exp_en: EN_ALL};
        vec[1] = '{value: 16'h12A4, err: 1'b0, exp_bcd: 16'h12A4, exp_err: 4'b0010, exp_en: EN_ALL};
        vec[2] = '{value: 16'h12A4, err: 1'b1, exp_bcd: 16'h12A4, exp_err: 4'b1111, exp_en: EN_ALL};
        vec[3] = '{value: 16'h0040, err: 1'b0, exp_bcd: 16'h0040, exp_err: 4'b0000, exp_en: EN_0040};
        vec[4] = '{value: 16'h0000, err: 1'b0, exp_bcd: 16'h0000, exp_err: 4'b0000, exp_en: EN_0000};
        vec[5] = '{value: 16'h0000, err: 1'b1, exp_bcd: 16'h0000, exp_err: 4'b1111, exp_en: EN_ALL};
        vec[6] = '{value: 16'hF090, err: 1'b0, exp_bcd: 16'hF090, exp_err: 4'b1000, exp_en: EN_ALL};

        rst = 1'b1; load = 1'b0; value_in = '0; err = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst digit_en_n", 16'(digit_en_n), 16'h000F);
        chk("rst bcd_out", 16'(bcd_out), 16'h0000);
        chk("rst err_out", 16'(err_out), 16'h0000);
        chk("rst pending", 16'(pending), 16'h0000);
        chk("rst frame_start", 16'(frame_start), 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("first frame_start", 16'(frame_start), 16'h0001);
        chk("first bcd_out", 16'(bcd_out), 16'h0000);
        $display("reset sequence checked");

        // Table vectors: load at k=0, displayed in the next frame
        for (int v = 0; v < NV; v++) begin
            load = 1'b1; value_in = vec[v].value; err = vec[v].err;
            @(negedge clk);
            load = 1'b0;
            chk("pending rise", 16'(pending), 16'h0001);
            wait_fs("vec frame");
            chk("pending fall", 16'(pending), 16'h0000);
            check_frame(vec[v].exp_bcd, vec[v].exp_err, vec[v].exp_en);
            err = 1'b0;
            $display("vec %0d value=%h err=%b checked", v, vec[v].value, vec[v].err);
        end

        // Double buffer: two mid-frame loads, last one wins at the next frame
        old = 16'hF090;
        step(5);
        load = 1'b1; value_in = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        chk("dbuf pending k6", 16'(pending), 16'h0001);
        chk("dbuf bcd k6", 16'(bcd_out), 16'(old[7:4]));
        @(negedge clk);
        load = 1'b1; value_in = 16'h0009;
        @(negedge clk);
        load = 1'b0;
        chk("dbuf pending k8", 16'(pending), 16'h0001);
        for (int k = 8; k < 16; k++) begin
            chk($sformatf("dbuf old bcd k=%0d", k), 16'(bcd_out), 16'(old[(k/4)*4 +: 4]));
            chk($sformatf("dbuf no fs k=%0d", k), 16'(frame_start), 16'h0000);
            @(negedge clk);
        end
        chk("dbuf fs", 16'(frame_start), 16'h0001);
        chk("dbuf pending clear", 16'(pending), 16'h0000);
        check_frame(16'h0009, 4'b0000, EN_0000);
        $display("double buffer sequence checked");

        // Load one cycle before the wrap (applied), then on the wrap (deferred)
        step(14);
        load = 1'b1; value_in = 16'h1234;
        @(negedge clk);
        value_in = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        chk("wrap fs", 16'(frame_start), 16'h0001);
        chk("wrap min latency bcd", 16'(bcd_out), 16'h0004);
        chk("wrap pending held", 16'(pending), 16'h0001);
        check_frame(16'h1234, 4'b0000, EN_ALL);
        chk("wrap deferred fs", 16'(frame_start), 16'h0001);
        chk("wrap deferred pending", 16'(pending), 16'h0000);
        chk("wrap deferred bcd", 16'(bcd_out), 16'h0005);
        $display("wrap-cycle load sequence checked");

        // Reset mid-slot discards pending value
        step(2);
        load = 1'b1; value_in = 16'h7777;
        @(negedge clk);
        load = 1'b0;
        chk("midrst pending set", 16'(pending), 16'h0001);
        step(3);
        rst = 1'b1; err = 1'b1;
        @(negedge clk);
        chk("midrst digit_en_n", 16'(digit_en_n), 16'h000F);
        chk("midrst bcd_out", 16'(bcd_out), 16'h0000);
        chk("midrst err_out", 16'(err_out), 16'h0000);
        chk("midrst pending", 16'(pending), 16'h0000);
        chk("midrst frame_start", 16'(frame_start), 16'h0000);
        rst = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("postrst fs", 16'(frame_start), 16'h0001);
        step(4);
        chk("postrst slot1 bcd", 16'(bcd_out), 16'h0000);
        step(12);
        chk("postrst next fs", 16'(frame_start), 16'h0001);
        chk("postrst next bcd", 16'(bcd_out), 16'h0000);
        chk("postrst next pending", 16'(pending), 16'h0000);
        $display("mid-slot reset sequence checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
